// File: rtl/lcd_bus_scheduler.sv
// Write-bus owner for the 128x64 graphic LCD: replays the power-up command
// sequence, then shares the bus round-robin between two byte requesters.
module lcd_bus_scheduler #(
  parameter int CLK_DIV      = 2500,
  parameter int CLEAR_PHASES = 32
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       init_done
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = $clog2(CLEAR_PHASES + 1);

  typedef enum logic [2:0] {
    INIT_LOAD = 3'd0,
    SETUP     = 3'd1,
    EN_HI     = 3'd2,
    EN_LO     = 3'd3,
    CLR_WAIT  = 3'd4,
    IDLE      = 3'd5
  } state_t;

  // Power-up commands: 8-bit basic set, display on, clear, entry mode.
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] val;
    case (idx)
      2'd0:    val = 8'h30;
      2'd1:    val = 8'h0C;
      2'd2:    val = 8'h01;
      2'd3:    val = 8'h06;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [1:0]        init_idx_q, init_idx_d;
  logic              last_grant_q, last_grant_d;
  logic              lcd_en_q, lcd_en_d;
  logic              lcd_rs_q, lcd_rs_d;
  logic [7:0]        lcd_data_q, lcd_data_d;
  logic              busy_q, busy_d;
  logic              init_done_q, init_done_d;

  logic              div_end_s;
  logic              phase_end_s;
  logic              grant_win_s;
  logic              pick0_s;
  logic              pick1_s;

  assign div_end_s   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign phase_end_s = (phase_cnt_q == PH_W'(CLEAR_PHASES - 1));

  // Round-robin pick: on a tie the requester that was not served last wins.
  assign grant_win_s = (state_q == IDLE) && init_done_q;
  assign pick0_s     = req0_valid && (!req1_valid || last_grant_q);
  assign pick1_s     = req1_valid && (!req0_valid || !last_grant_q);
  assign req0_ready  = grant_win_s && pick0_s;
  assign req1_ready  = grant_win_s && pick1_s;

  assign lcd_rw    = 1'b0;
  assign lcd_en    = lcd_en_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_data  = lcd_data_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;

  // Next-state and next-output computation for the bus sequencer.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q + DIV_W'(1);
    phase_cnt_d  = phase_cnt_q;
    init_idx_d   = init_idx_q;
    last_grant_d = last_grant_q;
    lcd_en_d     = lcd_en_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_data_d   = lcd_data_q;
    busy_d       = busy_q;
    init_done_d  = init_done_q;

    case (state_q)
      INIT_LOAD: begin
        lcd_rs_d   = 1'b0;
        lcd_data_d = init_rom(init_idx_q);
        lcd_en_d   = 1'b0;
        busy_d     = 1'b1;
        div_cnt_d  = '0;
        state_d    = SETUP;
      end

      SETUP: begin
        if (div_end_s) begin
          div_cnt_d = '0;
          lcd_en_d  = 1'b1;
          state_d   = EN_HI;
        end else begin
          lcd_en_d  = 1'b0;
        end
      end

      EN_HI: begin
        if (div_end_s) begin
          div_cnt_d = '0;
          lcd_en_d  = 1'b0;
          state_d   = EN_LO;
        end else begin
          lcd_en_d  = 1'b1;
        end
      end

      EN_LO: begin
        if (div_end_s) begin
          div_cnt_d = '0;
          if (!init_done_q && (init_idx_q == 2'd2)) begin
            // The clear command needs far longer than a normal write.
            phase_cnt_d = '0;
            state_d     = CLR_WAIT;
          end else if (!init_done_q && (init_idx_q != 2'd3)) begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = INIT_LOAD;
          end else if (!init_done_q) begin
            init_done_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          lcd_en_d = 1'b0;
        end
      end

      CLR_WAIT: begin
        if (div_end_s) begin
          div_cnt_d = '0;
          if (phase_end_s) begin
            phase_cnt_d = '0;
            init_idx_d  = init_idx_q + 2'd1;
            state_d     = INIT_LOAD;
          end else begin
            phase_cnt_d = phase_cnt_q + PH_W'(1);
          end
        end else begin
          phase_cnt_d = phase_cnt_q;
        end
      end

      IDLE: begin
        div_cnt_d = '0;
        if (req0_ready) begin
          lcd_rs_d     = req0_rs;
          lcd_data_d   = req0_data;
          last_grant_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = SETUP;
        end else if (req1_ready) begin
          lcd_rs_d     = req1_rs;
          lcd_data_d   = req1_data;
          last_grant_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = SETUP;
        end else begin
          busy_d = 1'b0;
        end
      end

      default: begin
        div_cnt_d = '0;
        lcd_en_d  = 1'b0;
        busy_d    = 1'b1;
        state_d   = INIT_LOAD;
      end
    endcase
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT_LOAD;
      div_cnt_q    <= '0;
      phase_cnt_q  <= '0;
      init_idx_q   <= 2'd0;
      last_grant_q <= 1'b1;
      lcd_en_q     <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      busy_q       <= 1'b1;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      phase_cnt_q  <= phase_cnt_d;
      init_idx_q   <= init_idx_d;
      last_grant_q <= last_grant_d;
      lcd_en_q     <= lcd_en_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_data_q   <= lcd_data_d;
      busy_q       <= busy_d;
      init_done_q  <= init_done_d;
    end
  end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Randomised bench for lcd_bus_scheduler, compared every cycle against a
// timeline model of the init schedule and the round-robin byte grants.
module tb_lcd_bus_scheduler;

  localparam int D  = 4;
  localparam int CP = 2;
  localparam int TX = 3 * D + 1;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_rs = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_rs = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       lcd_rs, lcd_rw, lcd_en, busy, init_done;
  logic [7:0] lcd_data;

  lcd_bus_scheduler #(.CLK_DIV(D), .CLEAR_PHASES(CP)) dut (
    .clock(clock), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
    .busy(busy), .init_done(init_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: cycle index since reset release, start cycle of the
  // current byte (load or accept), and the first cycle the bus is free.
  logic [7:0] rom [4] = '{8'h30, 8'h0C, 8'h01, 8'h06};
  int         cyc, start_cyc, idle_at, init_end;
  logic       last_grant;
  logic       shown_rs, pend_rs;
  logic [7:0] shown_data, pend_data;
  logic       acc0_prev, acc1_prev;

  function automatic int init_load(input int k);
    return k * TX + ((k == 3) ? CP * D : 0);
  endfunction

  task automatic model_reset();
    cyc        = 0;
    start_cyc  = -100;
    init_end   = init_load(3) + TX;
    idle_at    = init_end;
    last_grant = 1'b1;
    shown_rs   = 1'b0;
    shown_data = 8'h00;
    pend_rs    = 1'b0;
    pend_data  = 8'h00;
    acc0_prev  = 1'b0;
    acc1_prev  = 1'b0;
  endtask

  // mode 0: silent, 1: random with valid percentages p0/p1, 2: permanent contention
  task automatic gen_req(input int mode, input int p0, input int p1);
    if (mode == 0) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end else if (mode == 2) begin
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h11;
      req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h22;
    end else begin
      if (req0_valid && !acc0_prev) begin
        if ($urandom_range(15) == 0) req0_valid = 1'b0;
      end else begin
        req0_valid = ($urandom_range(99) < p0);
        req0_rs    = 1'($urandom_range(1));
        req0_data  = 8'($urandom);
      end
      if (req1_valid && !acc1_prev) begin
        if ($urandom_range(15) == 0) req1_valid = 1'b0;
      end else begin
        req1_valid = ($urandom_range(99) < p1);
        req1_rs    = 1'($urandom_range(1));
        req1_data  = 8'($urandom);
      end
    end
  endtask

  // One cycle: drive at the falling edge, compare, then advance the model.
  task automatic run_cycle(input int mode, input int p0, input int p1);
    logic e_r0, e_r1, e_en, win;
    gen_req(mode, p0, p1);
    #1;
    win  = (cyc >= idle_at);
    e_r0 = win && req0_valid && (!req1_valid || last_grant);
    e_r1 = win && req1_valid && (!req0_valid || !last_grant);
    e_en = (cyc >= start_cyc + D + 1) && (cyc <= start_cyc + 2 * D);
    check_eq("req0_ready", 32'(req0_ready), 32'(e_r0));
    check_eq("req1_ready", 32'(req1_ready), 32'(e_r1));
    check_eq("lcd_en",     32'(lcd_en),     32'(e_en));
    check_eq("lcd_rs",     32'(lcd_rs),     32'(shown_rs));
    check_eq("lcd_data",   32'(lcd_data),   32'(shown_data));
    check_eq("lcd_rw",     32'(lcd_rw),     32'd0);
    check_eq("busy",       32'(busy),       32'(cyc < idle_at));
    check_eq("init_done",  32'(init_done),  32'(cyc >= init_end));

    acc0_prev = 1'b0;
    acc1_prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (cyc == init_load(k)) begin
        start_cyc = cyc;
        pend_rs   = 1'b0;
        pend_data = rom[k];
      end
    end
    if (e_r0) begin
      start_cyc = cyc; pend_rs = req0_rs; pend_data = req0_data;
      last_grant = 1'b0; idle_at = cyc + TX; acc0_prev = 1'b1;
    end else if (e_r1) begin
      start_cyc = cyc; pend_rs = req1_rs; pend_data = req1_data;
      last_grant = 1'b1; idle_at = cyc + TX; acc1_prev = 1'b1;
    end
    if (start_cyc == cyc) begin
      shown_rs   = pend_rs;
      shown_data = pend_data;
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_en"},   32'(lcd_en),     32'd0);
    check_eq({tag, "_rs"},   32'(lcd_rs),     32'd0);
    check_eq({tag, "_data"}, 32'(lcd_data),   32'd0);
    check_eq({tag, "_done"}, 32'(init_done),  32'd0);
    check_eq({tag, "_busy"}, 32'(busy),       32'd1);
    check_eq({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
    check_eq({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
  endtask

  initial begin
    bit found;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_reset_values("rst");
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();

    repeat (70)  run_cycle(0, 0, 0);
    repeat (60)  run_cycle(2, 0, 0);
    repeat (500) run_cycle(1, 50, 50);
    repeat (400) run_cycle(1, 100, 5);
    repeat (400) run_cycle(1, 12, 12);

    // Hunt for an enable-high cycle, then pull reset in the middle of it.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((cyc >= start_cyc + D + 1) && (cyc <= start_cyc + 2 * D) && (cyc > init_end))
        found = 1'b1;
      else
        run_cycle(1, 100, 100);
    end
    check_eq("en_hunt", 32'(found), 32'd1);
    if (found) begin
      #1;
      check_eq("en_pre_rst", 32'(lcd_en), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_rst");
      @(posedge clock);
      @(posedge clock);
      #1;
      check_reset_values("hold_rst");
      @(negedge clock);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
      model_reset();
      repeat (70)  run_cycle(0, 0, 0);
      repeat (300) run_cycle(1, 60, 40);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
